life_row_engine: RTL

- Streaming Game-of-Life generation engine. Accepts one board row of WIDTH cells per handshake and emits the next-generation row.
- Uses a two-row sliding window, so the board height is unbounded and defined by the frame-last flag.
- Generalises the single-cell update to a full row per cycle. Adds programmable birth/survival rules, optional column wrap, backpressure, and per-frame statistics.
- Sits between the board memory read port and its write-back port.

---
 rtl/life_row_engine.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/life_row_engine.sv
// Streaming Game-of-Life row engine: accepts one board row per handshake and
// emits the next-generation row using a two-row sliding window.
module life_row_engine #(
  parameter int WIDTH = 32,
  parameter int GEN_W = 16,
  parameter int POP_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [8:0]       i_birth_mask,
  input  logic [8:0]       i_surv_mask,
  input  logic             i_wrap_cols,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_row,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_row,
  output logic             o_last,
  output logic [GEN_W-1:0] o_gen_cnt,
  output logic [POP_W-1:0] o_pop_cnt,
  output logic             o_stat_valid
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] above_q, cur_q, below, next_row;
  logic [WIDTH+1:0] a_ext, c_ext, b_ext;
  logic [8:0]       birth_q, surv_q;
  logic             wrap_q;
  logic [3:0]       nbr;
  logic [POP_W-1:0] acc_q, pop_sat;
  logic [POP_W:0]   pop_sum;
  logic [CNT_W-1:0] row_pop;
  logic             slot_free, accept, emit, load, load_last;

  assign slot_free = !o_valid || i_ready;
  assign emit      = o_valid && i_ready;
  assign accept    = i_valid && o_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    o_ready   = 1'b0;
    load      = 1'b0;
    load_last = 1'b0;
    case (state_q)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_d = i_last ? FLUSH : RUN;
      end
      RUN: begin
        o_ready = slot_free;
        if (i_valid && slot_free) begin
          load = 1'b1;
          if (i_last) state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (slot_free) begin
          load      = 1'b1;
          load_last = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The row below the window is the incoming row, or all-dead when flushing.
  assign below = (state_q == FLUSH) ? '0 : i_row;

  always_comb begin
    a_ext    = {wrap_q & above_q[0], above_q, wrap_q & above_q[WIDTH-1]};
    c_ext    = {wrap_q & cur_q[0],   cur_q,   wrap_q & cur_q[WIDTH-1]};
    b_ext    = {wrap_q & below[0],   below,   wrap_q & below[WIDTH-1]};
    nbr      = '0;
    next_row = '0;
    for (int k = 0; k < WIDTH; k++) begin
      nbr = 4'(a_ext[k]) + 4'(a_ext[k+1]) + 4'(a_ext[k+2]) +
            4'(c_ext[k]) + 4'(c_ext[k+2]) +
            4'(b_ext[k]) + 4'(b_ext[k+1]) + 4'(b_ext[k+2]);
      next_row[k] = cur_q[k] ? surv_q[nbr] : birth_q[nbr];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      above_q <= '0;
      cur_q   <= '0;
      birth_q <= '0;
      surv_q  <= '0;
      wrap_q  <= 1'b0;
    end else if (state_q == FLUSH) begin
      if (slot_free) begin
        above_q <= '0;
        cur_q   <= '0;
      end
    end else if (accept) begin
      // Rules and wrap mode are frozen for the whole frame at its first row.
      if (state_q == IDLE) begin
        birth_q <= i_birth_mask;
        surv_q  <= i_surv_mask;
        wrap_q  <= i_wrap_cols;
        above_q <= '0;
      end else begin
        above_q <= cur_q;
      end
      cur_q <= i_row;
    end
  end

  always_comb begin
    row_pop = '0;
    for (int i = 0; i < WIDTH; i++) row_pop = row_pop + CNT_W'(o_row[i]);
  end

  assign pop_sum = {1'b0, acc_q} + (POP_W + 1)'(row_pop);
  assign pop_sat = pop_sum[POP_W] ? '1 : pop_sum[POP_W-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid      <= 1'b0;
      o_last       <= 1'b0;
      o_row        <= '0;
      o_gen_cnt    <= '0;
      o_pop_cnt    <= '0;
      o_stat_valid <= 1'b0;
      acc_q        <= '0;
    end else begin
      o_stat_valid <= 1'b0;
      if (load) begin
        o_row   <= next_row;
        o_valid <= 1'b1;
        o_last  <= load_last;
      end else if (emit) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
      if (emit) begin
        if (o_last) begin
          o_pop_cnt    <= pop_sat;
          o_stat_valid <= 1'b1;
          o_gen_cnt    <= o_gen_cnt + GEN_W'(1);
          acc_q        <= '0;
        end else begin
          acc_q <= pop_sat;
        end
      end
    end
  end

endmodule
